// File: rtl/dbg_rom_monitor.sv
// ROM response monitor: beat counter, last data, rotate-XOR signature, back-to-back flag.
// Optional build macro DBG_ROM_TRACE_EN adds a simulation-only trace of accepted beats.
module dbg_rom_dff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             stall,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     q <= '0;
    else if (clr)   q <= '0;
    else if (!stall) q <= d;
  end
endmodule

module dbg_rom_monitor #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid,
  input  logic [63:0]      data,
  input  logic             clr,
  output logic [CNT_W-1:0] beat_count,
  output logic [63:0]      last_data,
  output logic [63:0]      signature,
  output logic             b2b_err
);
  logic             valid_q;
  logic             cnt_sat;
  logic [CNT_W-1:0] cnt_d;
  logic [63:0]      sig_d;
  logic             b2b_d;

  assign cnt_sat = &beat_count;
  assign cnt_d   = beat_count + CNT_W'(1);
  assign sig_d   = {signature[62:0], signature[63]} ^ data;
  assign b2b_d   = b2b_err | (valid & valid_q);

  // Counter holds once saturated so it never wraps back to zero.
  dbg_rom_dff #(.WIDTH(CNT_W)) u_cnt (
    .clk(clk), .rst_n(rst_n), .clr(clr), .stall(~valid | cnt_sat),
    .d(cnt_d), .q(beat_count)
  );

  dbg_rom_dff #(.WIDTH(64)) u_last (
    .clk(clk), .rst_n(rst_n), .clr(clr), .stall(~valid),
    .d(data), .q(last_data)
  );

  dbg_rom_dff #(.WIDTH(64)) u_sig (
    .clk(clk), .rst_n(rst_n), .clr(clr), .stall(~valid),
    .d(sig_d), .q(signature)
  );

  dbg_rom_dff #(.WIDTH(1)) u_vq (
    .clk(clk), .rst_n(rst_n), .clr(clr), .stall(1'b0),
    .d(valid), .q(valid_q)
  );

  dbg_rom_dff #(.WIDTH(1)) u_b2b (
    .clk(clk), .rst_n(rst_n), .clr(clr), .stall(1'b0),
    .d(b2b_d), .q(b2b_err)
  );

`ifdef DBG_ROM_TRACE_EN
  // Reports the value the counter takes at this edge (saturated value once pinned).
  always @(posedge clk) begin
    if (rst_n && !clr && valid) begin
      $display("[dbg_rom] #%0d data=%016h", cnt_sat ? beat_count : cnt_d, data);
      if (valid_q && !b2b_err)
        $display("[dbg_rom] ERROR back-to-back valid");
    end
  end
`endif
endmodule

// File: tb/tb_dbg_rom_monitor.sv
// Directed bench for dbg_rom_monitor: default-width instance plus a 4-bit counter instance.
module tb_dbg_rom_monitor;
  logic        clk;
  logic        rst_n;
  logic        valid;
  logic [63:0] data;
  logic        clr;
  logic [31:0] beat_count;
  logic [63:0] last_data;
  logic [63:0] signature;
  logic        b2b_err;
  logic [3:0]  beat_count4;
  logic [63:0] last_data4;
  logic [63:0] signature4;
  logic        b2b_err4;

  int checks = 0;
  int errors = 0;

  dbg_rom_monitor dut (
    .clk(clk), .rst_n(rst_n), .valid(valid), .data(data), .clr(clr),
    .beat_count(beat_count), .last_data(last_data), .signature(signature), .b2b_err(b2b_err)
  );

  dbg_rom_monitor #(.CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .valid(valid), .data(data), .clr(clr),
    .beat_count(beat_count4), .last_data(last_data4), .signature(signature4), .b2b_err(b2b_err4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One isolated beat followed by one idle cycle; outputs sampled on the negedge.
  task automatic pulse(input logic [63:0] d);
    @(negedge clk); valid = 1'b1; data = d;
    @(negedge clk); valid = 1'b0; data = 64'hDEAD_BEEF_DEAD_BEEF;
    @(negedge clk);
  endtask

  task automatic do_clr();
    @(negedge clk); clr = 1'b1;
    @(negedge clk); clr = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; valid = 1'b0; data = '0; clr = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (beat_count !== 32'd0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", beat_count); end
    checks++; if (last_data !== 64'd0) begin errors++; $display("FAIL reset_last got %h exp 0", last_data); end
    checks++; if (signature !== 64'd0) begin errors++; $display("FAIL reset_sig got %h exp 0", signature); end
    checks++; if (b2b_err !== 1'b0) begin errors++; $display("FAIL reset_b2b got %b exp 0", b2b_err); end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_basic();
    pulse(64'h1111);
    checks++; if (beat_count !== 32'd1) begin errors++; $display("FAIL basic_cnt1 got %0d exp 1", beat_count); end
    checks++; if (signature !== 64'h1111) begin errors++; $display("FAIL basic_sig1 got %h exp 1111", signature); end
    pulse(64'h2222);
    checks++; if (beat_count !== 32'd2) begin errors++; $display("FAIL basic_cnt2 got %0d exp 2", beat_count); end
    checks++; if (last_data !== 64'h2222) begin errors++; $display("FAIL basic_last got %h exp 2222", last_data); end
    checks++; if (signature !== 64'h0) begin errors++; $display("FAIL basic_sig2 got %h exp 0", signature); end
    checks++; if (b2b_err !== 1'b0) begin errors++; $display("FAIL basic_b2b got %b exp 0", b2b_err); end
  endtask

  task automatic test_rotate();
    do_clr();
    pulse(64'h8000_0000_0000_0000);
    checks++; if (signature !== 64'h8000_0000_0000_0000) begin errors++; $display("FAIL rot_sig1 got %h exp 8000000000000000", signature); end
    pulse(64'h0);
    checks++; if (signature !== 64'h1) begin errors++; $display("FAIL rot_sig2 got %h exp 1", signature); end
    checks++; if (last_data !== 64'h0) begin errors++; $display("FAIL rot_last got %h exp 0", last_data); end
    checks++; if (b2b_err !== 1'b0) begin errors++; $display("FAIL rot_b2b got %b exp 0", b2b_err); end
  endtask

  task automatic test_back_to_back();
    do_clr();
    @(negedge clk); valid = 1'b1; data = 64'h5;
    checks++; if (b2b_err !== 1'b0) begin errors++; $display("FAIL b2b_pre got %b exp 0", b2b_err); end
    @(negedge clk); data = 64'h6;
    checks++; if (b2b_err !== 1'b0) begin errors++; $display("FAIL b2b_first got %b exp 0", b2b_err); end
    @(negedge clk); valid = 1'b0; data = '0;
    checks++; if (beat_count !== 32'd2) begin errors++; $display("FAIL b2b_cnt got %0d exp 2", beat_count); end
    checks++; if (b2b_err !== 1'b1) begin errors++; $display("FAIL b2b_set got %b exp 1", b2b_err); end
    checks++; if (last_data !== 64'h6) begin errors++; $display("FAIL b2b_last got %h exp 6", last_data); end
    checks++; if (signature !== 64'hC) begin errors++; $display("FAIL b2b_sig got %h exp c", signature); end
    repeat (3) @(negedge clk);
    checks++; if (b2b_err !== 1'b1) begin errors++; $display("FAIL b2b_sticky got %b exp 1", b2b_err); end
    do_clr();
    checks++; if (beat_count !== 32'd0) begin errors++; $display("FAIL clr_cnt got %0d exp 0", beat_count); end
    checks++; if (last_data !== 64'd0) begin errors++; $display("FAIL clr_last got %h exp 0", last_data); end
    checks++; if (signature !== 64'd0) begin errors++; $display("FAIL clr_sig got %h exp 0", signature); end
    checks++; if (b2b_err !== 1'b0) begin errors++; $display("FAIL clr_b2b got %b exp 0", b2b_err); end
  endtask

  task automatic test_saturate();
    do_clr();
    for (int i = 1; i <= 17; i++) begin
      pulse(64'(i));
      if (i == 14) begin
        checks++; if (beat_count4 !== 4'hE) begin errors++; $display("FAIL sat_14 got %h exp e", beat_count4); end
      end
      if (i == 15) begin
        checks++; if (beat_count4 !== 4'hF) begin errors++; $display("FAIL sat_15 got %h exp f", beat_count4); end
      end
    end
    checks++; if (beat_count4 !== 4'hF) begin errors++; $display("FAIL sat_17 got %h exp f", beat_count4); end
    checks++; if (beat_count !== 32'd17) begin errors++; $display("FAIL sat_wide got %0d exp 17", beat_count); end
    checks++; if (last_data4 !== 64'd17) begin errors++; $display("FAIL sat_last got %h exp 11", last_data4); end
    checks++; if (b2b_err4 !== 1'b0) begin errors++; $display("FAIL sat_b2b got %b exp 0", b2b_err4); end
  endtask

  task automatic test_reset_mid();
    do_clr();
    pulse(64'h1); pulse(64'h2); pulse(64'h3);
    checks++; if (beat_count !== 32'd3) begin errors++; $display("FAIL mid_pre got %0d exp 3", beat_count); end
    @(negedge clk); valid = 1'b1; data = 64'h99;
    #2 rst_n = 1'b0;
    #1;
    checks++; if (beat_count !== 32'd0) begin errors++; $display("FAIL mid_async_cnt got %0d exp 0", beat_count); end
    checks++; if (signature !== 64'd0) begin errors++; $display("FAIL mid_async_sig got %h exp 0", signature); end
    @(negedge clk); valid = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    pulse(64'hABCD);
    checks++; if (beat_count !== 32'd1) begin errors++; $display("FAIL mid_cnt got %0d exp 1", beat_count); end
    checks++; if (last_data !== 64'hABCD) begin errors++; $display("FAIL mid_last got %h exp abcd", last_data); end
    checks++; if (signature !== 64'hABCD) begin errors++; $display("FAIL mid_sig got %h exp abcd", signature); end
  endtask

  task automatic test_clr_valid();
    pulse(64'h4);
    @(negedge clk); clr = 1'b1; valid = 1'b1; data = 64'h77;
    @(negedge clk); clr = 1'b0; valid = 1'b0; data = '0;
    checks++; if (beat_count !== 32'd0) begin errors++; $display("FAIL cv_cnt got %0d exp 0", beat_count); end
    checks++; if (last_data !== 64'd0) begin errors++; $display("FAIL cv_last got %h exp 0", last_data); end
    checks++; if (signature !== 64'd0) begin errors++; $display("FAIL cv_sig got %h exp 0", signature); end
    checks++; if (b2b_err !== 1'b0) begin errors++; $display("FAIL cv_b2b got %b exp 0", b2b_err); end
    // Beat right after a cleared beat must not flag back-to-back.
    @(negedge clk); clr = 1'b1; valid = 1'b1; data = 64'h1;
    @(negedge clk); clr = 1'b0; data = 64'h30;
    @(negedge clk); valid = 1'b0; data = '0;
    checks++; if (b2b_err !== 1'b0) begin errors++; $display("FAIL cv_vq got %b exp 0", b2b_err); end
    checks++; if (beat_count !== 32'd1) begin errors++; $display("FAIL cv_after_cnt got %0d exp 1", beat_count); end
    checks++; if (signature !== 64'h30) begin errors++; $display("FAIL cv_after_sig got %h exp 30", signature); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_rotate();
    test_back_to_back();
    test_saturate();
    test_reset_mid();
    test_clr_valid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
